// File: rtl/data_mem_ctrl_if.sv
// LSU <-> data-memory controller bus. Signal suffixes are relative to the controller:
// _i are driven by the LSU (master), _o by the controller (slave).
interface data_mem_ctrl_if;
  logic        mem_en_i;
  logic        data_req_i;
  logic        we_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        data_gnt_o;
  logic [31:0] rdata_o;
  logic        rvalid_o;
  logic        ack_o;
  logic        err_o;
  logic        busy_o;

  modport master (
    output mem_en_i, data_req_i, we_i, addr_i, wdata_i,
    input  data_gnt_o, rdata_o, rvalid_o, ack_o, err_o, busy_o
  );

  modport slave (
    input  mem_en_i, data_req_i, we_i, addr_i, wdata_i,
    output data_gnt_o, rdata_o, rvalid_o, ack_o, err_o, busy_o
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// Word-addressed data-memory controller with programmable wait states.
// Optional feature: define DMEM_RANGE_CHECK_EN to reject addresses beyond the array.
module data_mem_ctrl #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input logic             clock,
  input logic             reset,
  data_mem_ctrl_if.slave  bus
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {StIdle, StWait, StAccess, StErr} state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic            we_q, we_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     rdata_q;
  logic            rvalid_q, ack_q, err_q;
  logic            req_ok;

  logic [31:0]     mem [DEPTH_WORDS];

`ifdef DMEM_RANGE_CHECK_EN
  localparam logic [32:0] AddrLimit = 33'(DEPTH_WORDS) << 2;
  assign req_ok = bus.data_req_i && ({1'b0, bus.addr_i} < AddrLimit);
`else
  // High address bits alias onto the array.
  assign req_ok = bus.data_req_i;
`endif

  logic unused_addr;
  assign unused_addr = ^{bus.addr_i[31:AW+2], bus.addr_i[1:0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    unique case (state_q)
      StIdle: begin
        if (bus.mem_en_i) begin
          if (req_ok) begin
            idx_d   = bus.addr_i[AW+1:2];
            we_d    = bus.we_i;
            wdata_d = bus.wdata_i;
            if (WAIT_CYCLES == 0) begin
              state_d = StAccess;
            end else begin
              state_d = StWait;
              cnt_d   = 4'(WAIT_CYCLES);
            end
          end else begin
            state_d = StErr;
          end
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = StAccess;
      end
      StAccess: state_d = StIdle;
      StErr:    state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= 4'd0;
      idx_q    <= '0;
      we_q     <= 1'b0;
      wdata_q  <= 32'd0;
      rdata_q  <= 32'd0;
      rvalid_q <= 1'b0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      rvalid_q <= (state_q == StAccess) && !we_q;
      ack_q    <= (state_q == StAccess) && we_q;
      err_q    <= (state_q == StErr);
      if ((state_q == StAccess) && !we_q) rdata_q <= mem[idx_q];
    end
  end

  // Array is never reset; a reset pulls state_q out of StAccess before any write edge.
  always_ff @(posedge clock) begin
    if ((state_q == StAccess) && we_q) mem[idx_q] <= wdata_q;
  end

  assign bus.data_gnt_o = (state_q == StIdle);
  assign bus.busy_o     = (state_q != StIdle);
  assign bus.rdata_o    = rdata_q;
  assign bus.rvalid_o   = rvalid_q;
  assign bus.ack_o      = ack_q;
  assign bus.err_o      = err_q;

endmodule
